// File: rtl/id_scoreboard.sv
// id_scoreboard: RAW-hazard scoreboard for the decode stage.
// Each architectural register has a counter of in-flight writes. The status
// register has its own counter of pending S-bit writers. A decode instruction
// stalls while any register it reads, or the SR when it is conditional, still
// has a pending writer. It also stalls when its own destination counter, or
// the SR counter, is already saturated.
// Ports:
//   clk, rst             clock (rising edge), async active-low reset
//   issue_*              decode-stage instruction (valid, dest write, S, cond)
//   src1_en/src1,
//   two_src/src2         source operands read by the decode instruction
//   flush                decode instruction is killed this cycle
//   wb_en/wb_dest        register write retiring at writeback
//   sr_retire            SR update retiring this cycle
//   hazard, issue_fire   combinational stall / accept for the decode stage
//   busy_vec, sr_busy    per-register and SR pending flags
//   inflight             total pending register writes
//   err_underflow        sticky: a retire arrived with no pending write
module id_scoreboard #(
  parameter int unsigned NREGS     = 16,
  parameter int unsigned RAW       = 4,
  parameter int unsigned CNT_W     = 2,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic                   issue_wb_en,
  input  logic [RAW-1:0]         issue_dest,
  input  logic                   issue_s,
  input  logic                   issue_cond,
  input  logic                   src1_en,
  input  logic [RAW-1:0]         src1,
  input  logic                   two_src,
  input  logic [RAW-1:0]         src2,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [RAW-1:0]         wb_dest,
  input  logic                   sr_retire,
  output logic                   hazard,
  output logic                   issue_fire,
  output logic [NREGS-1:0]       busy_vec,
  output logic                   sr_busy,
  output logic [RAW+CNT_W-1:0]   inflight,
  output logic                   err_underflow
);

  localparam int unsigned IF_W = RAW + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [CNT_W-1:0] sr_cnt_q, sr_cnt_d;
  logic [IF_W-1:0]  inflight_q, inflight_d;
  logic             err_q, err_d;

  logic [NREGS-1:0] pend_vec;
  logic             h1, h2, h3, h4, h5;
  logic             same_reg, inc_eff, dec_eff, reg_uf, sr_inc, sr_uf;

  // Pending per register; a last write retiring this cycle is forwarded by
  // the write-through register file, so it no longer blocks a reader.
  always_comb begin
    pend_vec = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      pend_vec[i] = (cnt_q[i] != '0) &
                    ~(WB_BYPASS & (cnt_q[i] == CNT_W'(1)) & wb_en &
                      (wb_dest == RAW'(i)));
    end
  end

  // Hazard and accept for the decode instruction.
  always_comb begin
    h1         = src1_en & pend_vec[src1];
    h2         = two_src & pend_vec[src2];
    h3         = issue_wb_en & (cnt_q[issue_dest] == CNT_MAX);
    h4         = issue_cond & (sr_cnt_q != '0);
    h5         = issue_s & (sr_cnt_q == CNT_MAX);
    hazard     = issue_valid & ~flush & (h1 | h2 | h3 | h4 | h5);
    issue_fire = issue_valid & ~flush & ~hazard;
  end

  // Counter next state: issue and retire on the same register cancel out.
  always_comb begin
    same_reg   = issue_fire & issue_wb_en & wb_en & (wb_dest == issue_dest);
    inc_eff    = issue_fire & issue_wb_en & ~same_reg;
    dec_eff    = wb_en & ~same_reg & (cnt_q[wb_dest] != '0);
    reg_uf     = wb_en & ~same_reg & (cnt_q[wb_dest] == '0);
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_eff && (issue_dest == RAW'(i))) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_eff && (wb_dest == RAW'(i))) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    inflight_d = inflight_q + IF_W'(inc_eff) - IF_W'(dec_eff);

    sr_inc   = issue_fire & issue_s;
    sr_uf    = sr_retire & ~sr_inc & (sr_cnt_q == '0);
    sr_cnt_d = sr_cnt_q;
    if (sr_inc && !sr_retire) begin
      sr_cnt_d = sr_cnt_q + CNT_W'(1);
    end else if (sr_retire && !sr_inc && (sr_cnt_q != '0)) begin
      sr_cnt_d = sr_cnt_q - CNT_W'(1);
    end

    err_d = err_q | reg_uf | sr_uf;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        cnt_q[i] <= '0;
      end
      sr_cnt_q   <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sr_cnt_q   <= sr_cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Status flags decoded straight from the counter registers.
  always_comb begin
    busy_vec = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_vec[i] = (cnt_q[i] != '0);
    end
    sr_busy       = (sr_cnt_q != '0);
    inflight      = inflight_q;
    err_underflow = err_q;
  end

endmodule
